// File: rtl/pcie_gearbox_128b130b.sv
// 128b/130b gearbox: prepends the sync header to each scrambled 128-bit block and
// packs the 130-bit blocks LSB-first into 128-bit words, 64 blocks per 65 words.
module pcie_gearbox_128b130b #(
  parameter int unsigned DW       = 128,
  parameter logic [1:0]  HDR_DATA = 2'b01,
  parameter logic [1:0]  HDR_OS   = 2'b10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_is_ctl,
  output logic          in_ready,
  input  logic          align_clr,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_block_start,
  output logic [6:0]    out_seq
);

  localparam logic [6:0] DRAIN_CNT = 7'd64;

  logic [DW-1:0]   res_q, res_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            block_start_q, block_start_d;
  logic [6:0]      out_seq_q, out_seq_d;

  logic [1:0]      hdr;
  logic [DW+1:0]   blk;
  logic [6:0]      shift;
  logic [2*DW-1:0] comb_w;

  assign in_ready = !align_clr && (cnt_q != DRAIN_CNT);

  assign hdr   = in_is_ctl ? HDR_OS : HDR_DATA;
  assign blk   = {in_data, hdr};
  // Residual holds 2*cnt bits; bits above that are kept at zero so a plain OR merges.
  assign shift = {cnt_q[5:0], 1'b0};
  assign comb_w = {{DW{1'b0}}, res_q} | ({{(DW-2){1'b0}}, blk} << shift);

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    res_d         = res_q;
    cnt_d         = cnt_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    block_start_d = 1'b0;
    out_seq_d     = out_seq_q;
    if (align_clr) begin
      res_d = '0;
      cnt_d = '0;
    end else if (cnt_q == DRAIN_CNT) begin
      out_data_d  = res_q;
      out_valid_d = 1'b1;
      out_seq_d   = cnt_q;
      res_d       = '0;
      cnt_d       = '0;
    end else if (in_valid) begin
      out_data_d    = comb_w[DW-1:0];
      out_valid_d   = 1'b1;
      block_start_d = (cnt_q == '0);
      out_seq_d     = cnt_q;
      res_d         = comb_w[2*DW-1:DW];
      cnt_d         = cnt_q + 7'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q         <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      block_start_q <= 1'b0;
      out_seq_q     <= '0;
    end else begin
      res_q         <= res_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      block_start_q <= block_start_d;
      out_seq_q     <= out_seq_d;
    end
  end

  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;
  assign out_block_start = block_start_q;
  assign out_seq         = out_seq_q;

endmodule

// File: tb/tb_pcie_gearbox_128b130b.sv
// Bench for pcie_gearbox_128b130b: directed and random blocks compared against a
// bit-queue model of the 130b wire stream.
module tb_pcie_gearbox_128b130b;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_is_ctl;
  logic         in_ready;
  logic         align_clr;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_block_start;
  logic [6:0]   out_seq;

  pcie_gearbox_128b130b dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_is_ctl       (in_is_ctl),
    .in_ready        (in_ready),
    .align_clr       (align_clr),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_block_start (out_block_start),
    .out_seq         (out_seq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the wire bit stream not yet emitted, and words emitted since alignment.
  bit           q[$];
  int           words;
  logic [127:0] exp_data;
  int           accepted;

  // Observed values from the most recent cycle.
  logic         last_ready, last_valid, last_bs;
  logic [6:0]   last_seq;
  logic [127:0] last_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    words    = 0;
    exp_data = '0;
  endtask

  task automatic cycle(input logic v, input logic c, input logic [127:0] d, input logic clr);
    logic         exp_ready, exp_valid, exp_bs;
    logic [6:0]   exp_seq;
    logic [1:0]   hdr;
    @(negedge clk);
    in_valid  = v;
    in_is_ctl = c;
    in_data   = d;
    align_clr = clr;
    #1;
    exp_ready = !clr && (q.size() < 128);
    last_ready = in_ready;
    check("in_ready", {127'b0, in_ready}, {127'b0, exp_ready});
    exp_valid = 1'b0;
    exp_bs    = 1'b0;
    exp_seq   = '0;
    if (clr) begin
      q.delete();
      words = 0;
    end else if (q.size() == 128) begin
      for (int i = 0; i < 128; i++) exp_data[i] = q.pop_front();
      exp_valid = 1'b1;
      exp_seq   = 7'(words % 65);
      words++;
    end else if (v) begin
      exp_bs = (q.size() == 0);
      hdr = c ? 2'b10 : 2'b01;
      q.push_back(hdr[0]);
      q.push_back(hdr[1]);
      for (int i = 0; i < 128; i++) q.push_back(d[i]);
      for (int i = 0; i < 128; i++) exp_data[i] = q.pop_front();
      exp_valid = 1'b1;
      exp_seq   = 7'(words % 65);
      words++;
      accepted++;
    end
    @(posedge clk);
    #1;
    last_valid = out_valid;
    last_bs    = out_block_start;
    last_seq   = out_seq;
    last_data  = out_data;
    check("out_valid", {127'b0, out_valid}, {127'b0, exp_valid});
    check("out_data", out_data, exp_data);
    check("out_block_start", {127'b0, out_block_start}, {127'b0, exp_bs});
    if (exp_valid) check("out_seq", {121'b0, out_seq}, {121'b0, exp_seq});
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int first_nr, nwords, bs_count;
    logic [6:0] bs_w1, bs_w2;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_is_ctl = 1'b0;
    in_data   = rnd128();
    align_clr = 1'b0;
    accepted  = 0;
    model_reset();

    // Reset held with in_valid high: nothing comes out.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_out_valid", {127'b0, out_valid}, 128'b0);
      check("rst_out_data", out_data, 128'b0);
      check("rst_out_seq", {121'b0, out_seq}, 128'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("ready_after_rst", {127'b0, in_ready}, 128'b1);

    // Single data block of zeros.
    cycle(1'b1, 1'b0, '0, 1'b0);
    check("single_data", last_data, 128'h1);
    check("single_bs", {127'b0, last_bs}, 128'b1);
    check("single_seq", {121'b0, last_seq}, 128'b0);

    // Control block of ones after realignment, then a data block picks up bits 126,127.
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, '1, 1'b0);
    check("ctl_block", last_data, {{124{4'hF}}, 4'hE});
    cycle(1'b1, 1'b0, rnd128(), 1'b0);
    check("ctl_residual", {126'b0, last_data[1:0]}, 128'b11);

    // 64 back-to-back blocks from alignment, with in_valid held through the drain.
    cycle(1'b0, 1'b0, '0, 1'b1);
    first_nr = 0;
    nwords   = 0;
    bs_count = 0;
    bs_w1    = '0;
    bs_w2    = '0;
    for (int i = 1; i <= 66; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), rnd128(), 1'b0);
      if (!last_ready && first_nr == 0) first_nr = i;
      if (last_valid && i <= 65) nwords++;
      if (last_bs) begin
        bs_count++;
        if (bs_count == 1) bs_w1 = 7'(i);
        if (bs_count == 2) bs_w2 = 7'(i);
      end
    end
    check("drain_cycle", 128'(first_nr), 128'd65);
    check("period_words", 128'(nwords), 128'd65);
    check("bs_count", 128'(bs_count), 128'd2);
    check("bs_word1", {121'b0, bs_w1}, 128'd1);
    check("bs_word66", {121'b0, bs_w2}, 128'd66);

    // Random blocks with roughly 30% idle cycles; bounded cycle budget.
    accepted = 0;
    for (int cyc = 0; cyc < 5000 && accepted < 500; cyc++) begin
      cycle(($urandom_range(0, 99) >= 30), 1'($urandom_range(0, 1)), rnd128(), 1'b0);
    end
    check("random_accepted", 128'(accepted), 128'd500);

    // align_clr at cnt=5 together with in_valid.
    cycle(1'b0, 1'b0, '0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, rnd128(), 1'b0);
    cycle(1'b1, 1'b0, rnd128(), 1'b1);
    check("clr_not_ready", {127'b0, last_ready}, 128'b0);
    check("clr_no_valid", {127'b0, last_valid}, 128'b0);
    cycle(1'b1, 1'b1, rnd128(), 1'b0);
    check("clr_realigned_bs", {127'b0, last_bs}, 128'b1);
    check("clr_realigned_seq", {121'b0, last_seq}, 128'b0);
    repeat (20) cycle(1'b1, 1'($urandom_range(0, 1)), rnd128(), 1'b0);

    // Asynchronous reset mid-stream at cnt=40.
    cycle(1'b0, 1'b0, '0, 1'b1);
    repeat (40) cycle(1'b1, 1'($urandom_range(0, 1)), rnd128(), 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {127'b0, out_valid}, 128'b0);
    check("async_rst_data", out_data, 128'b0);
    check("async_rst_seq", {121'b0, out_seq}, 128'b0);
    check("async_rst_bs", {127'b0, out_block_start}, 128'b0);
    model_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    cycle(1'b1, 1'b0, rnd128(), 1'b0);
    check("post_rst_bs", {127'b0, last_bs}, 128'b1);
    check("post_rst_seq", {121'b0, last_seq}, 128'b0);
    repeat (70) cycle(1'b1, 1'($urandom_range(0, 1)), rnd128(), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
